// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited word reads,
// queues returned words for decode, and discards stale words after a redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam logic [SUM_W-1:0] DEPTH_SUM = SUM_W'(QUEUE_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(QUEUE_DEPTH - 1);

  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      out_pc_reg, out_pc_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] occupancy_reg, occupancy_next;
  logic [CNT_W-1:0] discard_reg, discard_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [31:0]      slot_reg [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] slot_we;

  logic [31:0]      redirect_target;
  logic [SUM_W-1:0] credit_used;
  logic             req_fire;
  logic             rsp_keep;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // Stale in-flight words still hold a credit until they come back and are dropped.
  assign credit_used    = SUM_W'(outstanding_reg) + SUM_W'(occupancy_reg);
  assign imem_req_valid = rst_n && !redirect && (credit_used < DEPTH_SUM);
  assign imem_req_addr  = fetch_pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_keep    = imem_rsp_valid && !redirect && (discard_reg == '0);
  assign instr_valid = (occupancy_reg != '0);
  assign pop         = instr_valid && instr_ready && !redirect;
  assign instr       = slot_reg[rd_ptr_reg];
  assign instr_pc    = out_pc_reg;

  for (genvar gi = 0; gi < QUEUE_DEPTH; gi++) begin : g_slot_we
    assign slot_we[gi] = rsp_keep && (wr_ptr_reg == PTR_W'(gi));
  end

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    out_pc_next      = out_pc_reg;
    outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
    occupancy_next   = occupancy_reg;
    discard_next     = discard_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;
    if (redirect) begin
      // A response landing in this cycle is already retired, so it is not in the discard count.
      fetch_pc_next  = redirect_target;
      out_pc_next    = redirect_target;
      occupancy_next = '0;
      discard_next   = outstanding_next;
      wr_ptr_next    = '0;
      rd_ptr_next    = '0;
    end else begin
      if (req_fire) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (imem_rsp_valid && (discard_reg != '0)) begin
        discard_next = discard_reg - CNT_W'(1);
      end
      if (rsp_keep) begin
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
        out_pc_next = out_pc_reg + 32'd4;
      end
      occupancy_next = occupancy_reg + CNT_W'(rsp_keep) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_reg    <= RESET_PC;
      out_pc_reg      <= RESET_PC;
      outstanding_reg <= '0;
      occupancy_reg   <= '0;
      discard_reg     <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      out_pc_reg      <= out_pc_next;
      outstanding_reg <= outstanding_next;
      occupancy_reg   <= occupancy_next;
      discard_reg     <= discard_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        slot_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (slot_we[i]) begin
          slot_reg[i] <= imem_rsp_data;
        end
      end
    end
  end

  // Counter bounds hold by construction; a response with nothing outstanding is a memory bug.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(imem_rsp_valid && (outstanding_reg == '0)));
      assert (!(req_fire && !imem_rsp_valid && (outstanding_reg == DEPTH_CNT)));
      assert (!(rsp_keep && !pop && (occupancy_reg == DEPTH_CNT)));
      assert (discard_reg <= outstanding_reg);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level reference model checked every cycle,
// a per-cycle vector table, directed redirect/wrap/reset sequences and a random run.
module tb_fetch_unit;
  localparam logic [31:0] RPC   = 32'h0000_0080;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // memory: in-order pending reads with a due cycle each
  logic [31:0] pend_addr [$];
  int          pend_due  [$];
  int          lat     = 1;
  bit          rnd_rsp = 1'b0;

  // reference model: next expected request address / delivered pc, queued word count, stale count
  logic [31:0] exp_fetch, exp_pc;
  int          m_occ, m_stale;

  logic        s_rv, s_iv, s_fire;
  logic [31:0] s_addr, s_instr, s_ipc;

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rr;
    logic        ir;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;
  vec_t tbl [18];

  logic [31:0] got_req [$];
  logic [31:0] got_pc  [$];
  logic [31:0] got_ins [$];
  logic [31:0] r_pc;
  logic        r_rd, r_rr, r_ir;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  task automatic model_reset();
    pend_addr.delete();
    pend_due.delete();
    exp_fetch = RPC;
    exp_pc    = RPC;
    m_occ     = 0;
    m_stale   = 0;
  endtask

  // One clock cycle: drive inputs, sample outputs, check against the model, advance the model.
  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic rr, input logic ir);
    logic exp_rv;
    logic do_pop;
    int   due;
    @(posedge clk);
    #1;
    cyc++;
    redirect       = rd;
    redirect_pc    = rpc;
    imem_req_ready = rr;
    instr_ready    = ir;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc && (!rnd_rsp || $urandom_range(0, 2) != 0)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = memfn(pend_addr[0]);
    end
    #1;
    s_rv    = imem_req_valid;
    s_addr  = imem_req_addr;
    s_iv    = instr_valid;
    s_instr = instr;
    s_ipc   = instr_pc;
    s_fire  = s_rv && rr;

    exp_rv = !rd && ((pend_addr.size() + m_occ) < DEPTH);
    chk("req_valid", 32'(s_rv), 32'(exp_rv));
    if (exp_rv && s_rv) chk("req_addr", s_addr, exp_fetch);
    chk("instr_valid", 32'(s_iv), 32'(m_occ > 0));
    if (m_occ > 0) begin
      chk("instr_pc", s_ipc, exp_pc);
      chk("instr", s_instr, memfn(exp_pc));
    end

    do_pop = !rd && (m_occ > 0) && ir;
    if (s_fire) begin
      due = rnd_rsp ? cyc + $urandom_range(1, 4) : cyc + lat;
      pend_addr.push_back(s_addr);
      pend_due.push_back(due);
      exp_fetch = exp_fetch + 32'd4;
    end
    if (imem_rsp_valid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      if (!rd) begin
        if (m_stale > 0) m_stale--;
        else m_occ++;
      end
    end
    if (do_pop) begin
      m_occ--;
      exp_pc = exp_pc + 32'd4;
    end
    if (rd) begin
      m_occ     = 0;
      exp_pc    = {rpc[31:2], 2'b00};
      exp_fetch = {rpc[31:2], 2'b00};
      m_stale   = pend_addr.size();
    end
  endtask

  task automatic collect(input int n);
    got_req.delete();
    got_pc.delete();
    got_ins.delete();
    for (int k = 0; k < n; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (s_fire) got_req.push_back(s_addr);
      if (s_iv) begin
        got_pc.push_back(s_ipc);
        got_ins.push_back(s_instr);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; instr_ready = 1'b0;
    model_reset();

    tbl[0]  = '{0, 32'h0,   1, 1, 1, 32'h80,  0, 32'h80};
    tbl[1]  = '{0, 32'h0,   1, 1, 1, 32'h84,  0, 32'h80};
    tbl[2]  = '{0, 32'h0,   1, 1, 0, 32'h88,  1, 32'h80};
    tbl[3]  = '{0, 32'h0,   1, 1, 1, 32'h88,  1, 32'h84};
    tbl[4]  = '{0, 32'h0,   1, 1, 1, 32'h8C,  0, 32'h88};
    tbl[5]  = '{0, 32'h0,   1, 1, 0, 32'h90,  1, 32'h88};
    tbl[6]  = '{0, 32'h0,   1, 1, 1, 32'h90,  1, 32'h8C};
    tbl[7]  = '{0, 32'h0,   1, 0, 1, 32'h94,  0, 32'h90};
    tbl[8]  = '{0, 32'h0,   1, 0, 0, 32'h98,  1, 32'h90};
    tbl[9]  = '{0, 32'h0,   1, 0, 0, 32'h98,  1, 32'h90};
    tbl[10] = '{0, 32'h0,   1, 0, 0, 32'h98,  1, 32'h90};
    tbl[11] = '{0, 32'h0,   1, 1, 0, 32'h98,  1, 32'h90};
    tbl[12] = '{0, 32'h0,   1, 1, 1, 32'h98,  1, 32'h94};
    tbl[13] = '{1, 32'hC03, 1, 1, 0, 32'h9C,  0, 32'h98};
    tbl[14] = '{0, 32'h0,   1, 1, 1, 32'hC00, 0, 32'hC00};
    tbl[15] = '{0, 32'h0,   1, 1, 1, 32'hC04, 0, 32'hC00};
    tbl[16] = '{0, 32'h0,   1, 1, 0, 32'hC08, 1, 32'hC00};
    tbl[17] = '{0, 32'h0,   1, 1, 1, 32'hC08, 1, 32'hC04};

    repeat (3) @(posedge clk);
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("rst_req_addr", imem_req_addr, RPC);
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_pc", instr_pc, RPC);
    $display("reset: req_valid=%0b addr=%h instr_valid=%0b pc=%h", imem_req_valid, imem_req_addr, instr_valid, instr_pc);
    @(posedge clk);
    #1 rst_n = 1'b1;

    lat = 1;
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].rd, tbl[i].rpc, tbl[i].rr, tbl[i].ir);
      chk("vec_req_valid", 32'(s_rv), 32'(tbl[i].rv));
      chk("vec_req_addr", s_addr, tbl[i].addr);
      chk("vec_instr_valid", 32'(s_iv), 32'(tbl[i].iv));
      chk("vec_instr_pc", s_ipc, tbl[i].ipc);
      if (tbl[i].iv) chk("vec_instr", s_instr, memfn(tbl[i].ipc));
      $display("vec %0d: rv=%0b addr=%h iv=%0b pc=%h", i, s_rv, s_addr, s_iv, s_ipc);
    end

    // redirect with two requests in flight on a slow memory
    for (int n = 0; n < 20 && (pend_addr.size() > 0 || m_occ > 0); n++) cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("drain_timeout", 32'(pend_addr.size() + m_occ), 32'h0);
    lat = 3;
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h1002, 1'b1, 1'b1);
    collect(20);
    chk("redir_req_seen", 32'(got_req.size() > 0), 32'h1);
    if (got_req.size() > 0) chk("redir_req_addr", got_req[0], 32'h1000);
    chk("redir_instr_seen", 32'(got_pc.size() > 0), 32'h1);
    if (got_pc.size() > 0) begin
      chk("redir_instr_pc", got_pc[0], 32'h1000);
      chk("redir_instr", got_ins[0], memfn(32'h1000));
      $display("redirect 0x1002: first req=%h first pc=%h", got_req[0], got_pc[0]);
    end

    // wrap at the top of the address space
    lat = 1;
    cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    collect(12);
    chk("wrap_req_count", 32'(got_req.size() >= 2), 32'h1);
    if (got_req.size() >= 2) begin
      chk("wrap_req0", got_req[0], 32'hFFFF_FFFC);
      chk("wrap_req1", got_req[1], 32'h0000_0000);
      $display("wrap: reqs %h %h", got_req[0], got_req[1]);
    end
    if (got_pc.size() >= 2) chk("wrap_pc1", got_pc[1], 32'h0000_0000);

    // back-to-back redirects with words in flight
    lat = 2;
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h3000, 1'b1, 1'b1);
    cycle(1'b1, 32'h4001, 1'b1, 1'b1);
    collect(15);
    chk("b2b_instr_seen", 32'(got_pc.size() > 0), 32'h1);
    if (got_pc.size() > 0) begin
      chk("b2b_instr_pc", got_pc[0], 32'h4000);
      $display("back-to-back redirect: first pc=%h", got_pc[0]);
    end

    // reset with the queue full
    lat = 1;
    for (int k = 0; k < 6; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fill_full", 32'(s_iv), 32'h1);
    @(posedge clk);
    #3;
    rst_n = 1'b0; redirect = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; instr_ready = 1'b0;
    #1;
    chk("mid_rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("mid_rst_req_valid", 32'(imem_req_valid), 32'h0);
    chk("mid_rst_instr_pc", instr_pc, RPC);
    chk("mid_rst_instr", instr, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    collect(5);
    chk("post_rst_req_seen", 32'(got_req.size() > 0), 32'h1);
    if (got_req.size() > 0) begin
      chk("post_rst_req_addr", got_req[0], RPC);
      $display("reset mid-run: first req after release=%h", got_req[0]);
    end

    // randomized traffic, memory latency and redirects
    rnd_rsp = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      r_rd = ($urandom_range(0, 29) == 0);
      r_pc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : ($urandom & 32'h0000_FFFF);
      r_rr = ($urandom_range(0, 3) != 0);
      r_ir = ($urandom_range(0, 2) != 0);
      cycle(r_rd, r_pc, r_rr, r_ir);
    end
    $display("random: 1500 cycles");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
